// File: rtl/decomp_pkg.sv
// decomp_pkg: shared state type, default pack depth and effective-length clamp for the decompressor sequencer
package decomp_pkg;
  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;
  localparam int MAX_PACK_DEF = 4;
  function automatic int eff_len(input logic encode, input int pack_len, input int max_pack);
    return !encode ? 1 : pack_len == 0 ? 1 : pack_len > max_pack ? max_pack : pack_len;
  endfunction
endpackage

// File: rtl/decomp_seq_ctrl_if.sv
// decomp_seq_ctrl_if: CPU-request inputs and datapath-control outputs of the sequencer; master drives requests, slave is the sequencer
interface decomp_seq_ctrl_if #(
  parameter int MAX_PACK = decomp_pkg::MAX_PACK_DEF,
  parameter int CNT_W = $clog2(MAX_PACK + 1)
);
  localparam int SLOT_W = $clog2(MAX_PACK);
  logic pc_req;
  logic branch;
  logic encode;
  logic [CNT_W-1:0] pack_len;
  logic branch_mux;
  logic pc_adv;
  logic in_load;
  logic table_sel;
  logic [SLOT_W-1:0] slot_sel;
  logic instr_valid;
  logic cached;
  modport master (
    output pc_req, branch, encode, pack_len,
    input branch_mux, pc_adv, in_load, table_sel, slot_sel, instr_valid, cached
  );
  modport slave (
    input pc_req, branch, encode, pack_len,
    output branch_mux, pc_adv, in_load, table_sel, slot_sel, instr_valid, cached
  );
endinterface

// File: rtl/flopr.sv
// flopr: enabled flop with synchronous active-high reset to a given value (clk, reset, rst_val, en, d -> q)
module flopr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] rst_val,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= reset ? rst_val : en ? d : q;
endmodule

// File: rtl/decomp_seq_ctrl.sv
// decomp_seq_ctrl: releases one expanded instruction per pc_req from words of up to MAX_PACK slots (clk, reset, bus=slave control interface)
module decomp_seq_ctrl
  import decomp_pkg::*;
#(
  parameter int MAX_PACK = MAX_PACK_DEF,
  parameter int CNT_W = $clog2(MAX_PACK + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  decomp_seq_ctrl_if.slave     bus
);
  localparam int SLOT_W = $clog2(MAX_PACK);
  logic              r_state_q;
  state_t            w_state;
  logic [SLOT_W-1:0] r_slot;
  logic [CNT_W-1:0]  r_len;
  state_t            w_n_state;
  logic [SLOT_W-1:0] w_n_slot;
  logic [CNT_W-1:0]  w_n_len;
  logic [CNT_W-1:0]  w_eff;
  logic              w_last;
  logic              w_multi;
  logic              w_en;
  assign w_state = state_t'(r_state_q);
  assign w_eff   = CNT_W'(eff_len(bus.encode, int'(bus.pack_len), MAX_PACK));
  assign w_multi = w_eff > CNT_W'(1);
  assign w_last  = CNT_W'(r_slot) == r_len - CNT_W'(1);
  assign w_en    = bus.branch | bus.pc_req;
  always_comb begin
    bus.branch_mux  = 1'b0;
    bus.pc_adv      = 1'b0;
    bus.in_load     = 1'b0;
    bus.instr_valid = 1'b0;
    bus.cached      = !reset && w_state == EXPAND;
    bus.table_sel   = !reset && w_state == EXPAND;
    bus.slot_sel    = (!reset && w_state == EXPAND) ? r_slot : '0;
    w_n_state       = w_state;
    w_n_slot        = r_slot;
    w_n_len         = r_len;
    if (reset) begin
      w_n_state = IDLE;
    end else if (bus.branch) begin
      bus.branch_mux = 1'b1;
      bus.pc_adv     = 1'b1;
      bus.in_load    = 1'b1;
      bus.table_sel  = 1'b0;
      bus.slot_sel   = '0;
      w_n_state      = IDLE;
      w_n_slot       = '0;
      w_n_len        = CNT_W'(1);
    end else if (bus.pc_req && w_state == IDLE) begin
      bus.instr_valid = 1'b1;
      bus.in_load     = 1'b1;
      bus.table_sel   = bus.encode;
      bus.pc_adv      = !w_multi;
      w_n_state       = w_multi ? EXPAND : IDLE;
      w_n_slot        = w_multi ? SLOT_W'(1) : '0;
      w_n_len         = w_multi ? w_eff : r_len;
    end else if (bus.pc_req) begin
      bus.instr_valid = 1'b1;
      bus.pc_adv      = w_last;
      w_n_state       = w_last ? IDLE : EXPAND;
      w_n_slot        = w_last ? '0 : r_slot + SLOT_W'(1);
    end
  end
  flopr #(.W(1)) u_state (
    .clk(clk), .reset(reset), .rst_val(1'b0), .en(w_en), .d(w_n_state), .q(r_state_q)
  );
  flopr #(.W(SLOT_W)) u_slot (
    .clk(clk), .reset(reset), .rst_val('0), .en(w_en), .d(w_n_slot), .q(r_slot)
  );
  flopr #(.W(CNT_W)) u_len (
    .clk(clk), .reset(reset), .rst_val(CNT_W'(1)), .en(w_en), .d(w_n_len), .q(r_len)
  );
endmodule

// File: doc/decomp_seq_ctrl.md
# decomp_seq_ctrl

Parametrised control sequencer for the instruction decompressor, generalising the two-instruction-per-word control unit to up to MAX_PACK instructions per compressed fetch word. It sits between the CPU fetch interface and the decompressor datapath (input buffer, decode table, output slot mux, compressed-memory PC). It releases one expanded instruction per CPU request and advances the compressed PC only after the last slot of a word. It also handles branch redirects mid-expansion.

## Interface
- MAX_PACK, 4: maximum instructions packed in one compressed word; must be at least 2.
- CNT_W, $clog2(MAX_PACK+1): width of pack_len.
- SLOT_W, $clog2(MAX_PACK): width of slot_sel. Derived locally; not overridable.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_req  in  1  CPU requests the next instruction this cycle.
- branch  in  1  CPU redirect (taken branch) this cycle.
- encode  in  1  word in the input buffer is table-compressed.
- pack_len  in  CNT_W  instruction count of the current compressed word; sampled only when encode=1.
- branch_mux  out  1  select branch target into the compressed PC.
- pc_adv  out  1  advance the compressed-memory PC.
- in_load  out  1  load the input buffer.
- table_sel  out  1  route the output through the decode table.
- slot_sel  out  SLOT_W  slot of the expanded word that drives the CPU output.
- instr_valid  out  1  output instruction is valid this cycle.
- cached  out  1  expansion in progress; remaining slots are still held.

## Operation
- State registers:
  - state: IDLE or EXPAND.
  - slot: SLOT_W bits.
  - len: CNT_W bits, the latched effective length.
- Effective length eff_len:
  - pack_len=0 gives 1.
  - pack_len>MAX_PACK gives MAX_PACK.
  - Otherwise eff_len = pack_len.
  - If encode=0, eff_len is 1.
- All outputs are combinational (Mealy) from the registers and the current inputs. cached = (state==EXPAND).
- Branch has priority in both states, with or without pc_req:
  - Outputs: branch_mux=1, pc_adv=1, in_load=1, instr_valid=0, table_sel=0, slot_sel=0.
  - Next state: IDLE, slot=0, len=1.
- IDLE with pc_req=1 and branch=0:
  - Outputs: instr_valid=1, in_load=1, slot_sel=0, table_sel=encode.
  - If eff_len>1: pc_adv=0; latch len=eff_len, slot=1, go to EXPAND.
  - If eff_len=1: pc_adv=1; stay in IDLE.
- EXPAND with pc_req=1 and branch=0:
  - Outputs: instr_valid=1, table_sel=1, in_load=0, slot_sel=slot.
  - If slot==len-1: pc_adv=1; go to IDLE with slot=0.
  - Otherwise: pc_adv=0; slot increments by 1.
- pc_req=0 and branch=0 (stall):
  - Strobes branch_mux, pc_adv, in_load and instr_valid are 0.
  - table_sel and slot_sel keep their state-derived values (slot_sel=slot in EXPAND, 0 in IDLE).
  - Registers hold.
- pack_len and encode are ignored in EXPAND. The latched len governs the word.

## Timing
- Reset:
  - While reset=1, every output is 0.
  - At the next edge: state=IDLE, slot=0, len=1.
  - Reset mid-EXPAND discards the remaining slots. No pc_adv is issued for the abandoned word.
- Strobe latency is zero cycles: outputs respond in the same cycle as pc_req/branch. State changes on the following rising edge.
- Throughput is one instruction per pc_req cycle. A word of length L yields exactly L instr_valid pulses, a single in_load (first slot), and a single pc_adv (last slot).
- Simultaneous branch and pc_req on the last slot: the branch wins. There is one pc_adv, with branch_mux=1, and instr_valid=0.
- slot never exceeds MAX_PACK-1. There is no wrap-around because the last-slot compare returns the block to IDLE.

## Structure
- Package decomp_pkg holds:
  - the state typedef (IDLE, EXPAND);
  - the default MAX_PACK constant;
  - the eff_len clamp as a function.
- The state, slot and len registers are built from the existing FLOPR flop (clk, reset, reset value, enable, d, q).
- Next-state and output logic sit in a single always_comb. No further sub-module.

## Test plan
All scenarios use MAX_PACK=4.
- Reset held 3 cycles, any inputs → all outputs 0. After release, pc_req=1, encode=0 for 3 cycles → instr_valid=pc_adv=in_load=1 and slot_sel=0 every cycle.
- encode=1, pack_len=3, pc_req=1 for 3 cycles:
  - slot_sel = 0,1,2;
  - table_sel=1 throughout;
  - in_load only in cycle 1;
  - pc_adv only in cycle 3;
  - cached = 0,1,1, then 0.
- pack_len=2, pc_req pattern 1,0,0,1 → slot_sel holds 1 during the stall with no strobes. The second instruction is released in cycle 4 with pc_adv=1.
- pack_len=4, branch=1 on slot 1 → branch_mux=pc_adv=1 and instr_valid=0. The next pc_req returns slot_sel=0 with in_load=1.
- pack_len=0, then pack_len=7 → treated as lengths 1 and 4 respectively (pc_adv after 1 and after 4 requests).
- Reset asserted in EXPAND at slot 2 → outputs 0 that cycle. Next pc_req is handled from IDLE with slot_sel=0 and in_load=1.
